// File: rtl/frame_buf_sched.sv
// frame_buf_sched: shares the frame buffer port between scan-out reads (priority)
// and a rectangle fill engine that writes one 4-pixel word per free cycle.
// Define FRAME_FILL_CLIP_EN to build clipping of fills to the 640x480 screen.
module frame_buf_sched (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        vid_req,
   input  logic [16:0] vid_addr,
   output logic        vid_gnt,
   output logic [31:0] vid_rdata,
   output logic        vid_rvalid,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_x,
   input  logic [8:0]  cmd_y,
   input  logic [9:0]  cmd_w,
   input  logic [8:0]  cmd_h,
   input  logic [7:0]  cmd_color,
   output logic        fill_busy,
   output logic        fill_done,
   output logic [16:0] frame_buf_address,
   output logic        frame_buf_chipselect,
   output logic        frame_buf_clken,
   output logic        frame_buf_write,
   output logic [31:0] frame_buf_writedata,
   output logic [3:0]  frame_buf_byteenable,
   input  logic [31:0] frame_buf_readdata
);
   localparam int unsigned H_WORDS = 160;
   localparam int unsigned AW      = 17;
   localparam int unsigned DW      = 32;
`ifdef FRAME_FILL_CLIP_EN
   localparam int unsigned V_LINES = 480;
   localparam int unsigned H_PIX   = H_WORDS * 4;
`endif

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_DONE} state_t;

   state_t          state_q;
   logic [9:0]      x_q;
   logic [8:0]      y_q;
   logic [9:0]      w_q;
   logic [8:0]      h_q;
   logic [7:0]      color_q;
   logic [8:0]      cur_word_q;
   logic [8:0]      first_word_q;
   logic [8:0]      last_word_q;
   logic [AW-1:0]   row_base_q;
   logic [8:0]      rows_left_q;
   logic [3:0]      first_be_q;
   logic [3:0]      last_be_q;
   logic            cmd_ready_q;
   logic            fill_busy_q;
   logic            fill_done_q;

   logic [AW-1:0]   fb_addr_q;
   logic            fb_cs_q;
   logic            fb_wr_q;
   logic [DW-1:0]   fb_wdata_q;
   logic [3:0]      fb_be_q;
   logic            fb_clken_q;
   logic            rd_pend_q;
   logic            rvalid_q;

   logic [10:0]     x1_c;
   logic [9:0]      y1_c;
   logic            empty_c;
   logic [AW-1:0]   wr_addr_c;
   logic [3:0]      wr_be_c;

   // Video always wins the port; reset blocks grants.
   assign vid_gnt   = vid_req & reset_reset_n;
   assign vid_rdata = rvalid_q ? frame_buf_readdata : '0;

   assign vid_rvalid           = rvalid_q;
   assign cmd_ready            = cmd_ready_q;
   assign fill_busy            = fill_busy_q;
   assign fill_done            = fill_done_q;
   assign frame_buf_address    = fb_addr_q;
   assign frame_buf_chipselect = fb_cs_q;
   assign frame_buf_clken      = fb_clken_q;
   assign frame_buf_write      = fb_wr_q;
   assign frame_buf_writedata  = fb_wdata_q;
   assign frame_buf_byteenable = fb_be_q;

   // Far corner of the latched rectangle and emptiness test, optionally clipped.
   always_comb begin
      x1_c    = 11'(x_q) + 11'(w_q) - 11'd1;
      y1_c    = 10'(y_q) + 10'(h_q) - 10'd1;
      empty_c = (w_q == 10'd0) || (h_q == 9'd0);
`ifdef FRAME_FILL_CLIP_EN
      empty_c = empty_c || (x_q >= 10'(H_PIX)) || (y_q >= 9'(V_LINES));
      if (x1_c > 11'(H_PIX - 1))   x1_c = 11'(H_PIX - 1);
      if (y1_c > 10'(V_LINES - 1)) y1_c = 10'(V_LINES - 1);
`endif
   end

   // Address and byte mask of the word the fill engine currently wants to write.
   always_comb begin
      wr_addr_c = row_base_q + AW'(cur_word_q);
      wr_be_c   = 4'hF;
      if (cur_word_q == first_word_q) wr_be_c = wr_be_c & first_be_q;
      if (cur_word_q == last_word_q)  wr_be_c = wr_be_c & last_be_q;
   end

   // Registered memory port and the two-stage video read return pipeline.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         fb_addr_q  <= '0;
         fb_cs_q    <= 1'b0;
         fb_wr_q    <= 1'b0;
         fb_wdata_q <= '0;
         fb_be_q    <= 4'hF;
         fb_clken_q <= 1'b1;
         rd_pend_q  <= 1'b0;
         rvalid_q   <= 1'b0;
      end else begin
         fb_clken_q <= 1'b1;
         rd_pend_q  <= vid_gnt;
         rvalid_q   <= rd_pend_q;
         if (vid_gnt) begin
            fb_addr_q <= vid_addr;
            fb_cs_q   <= 1'b1;
            fb_wr_q   <= 1'b0;
            fb_be_q   <= 4'hF;
         end else if (state_q == S_WRITE) begin
            fb_addr_q  <= wr_addr_c;
            fb_cs_q    <= 1'b1;
            fb_wr_q    <= 1'b1;
            fb_wdata_q <= {4{color_q}};
            fb_be_q    <= wr_be_c;
         end else begin
            fb_cs_q <= 1'b0;
            fb_wr_q <= 1'b0;
         end
      end
   end

   // Fill FSM: accept, set up row/word bounds, walk words in raster order, pulse done.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         w_q          <= '0;
         h_q          <= '0;
         color_q      <= '0;
         cur_word_q   <= '0;
         first_word_q <= '0;
         last_word_q  <= '0;
         row_base_q   <= '0;
         rows_left_q  <= '0;
         first_be_q   <= 4'hF;
         last_be_q    <= 4'hF;
         cmd_ready_q  <= 1'b1;
         fill_busy_q  <= 1'b0;
         fill_done_q  <= 1'b0;
      end else begin
         fill_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  x_q         <= cmd_x;
                  y_q         <= cmd_y;
                  w_q         <= cmd_w;
                  h_q         <= cmd_h;
                  color_q     <= cmd_color;
                  cmd_ready_q <= 1'b0;
                  fill_busy_q <= 1'b1;
                  state_q     <= S_SETUP;
               end
            end
            S_SETUP: begin
               first_word_q <= 9'(x_q[9:2]);
               cur_word_q   <= 9'(x_q[9:2]);
               last_word_q  <= x1_c[10:2];
               row_base_q   <= AW'(y_q) * AW'(H_WORDS);
               rows_left_q  <= 9'(y1_c - 10'(y_q));
               first_be_q   <= 4'hF << x_q[1:0];
               last_be_q    <= 4'hF >> (2'd3 - x1_c[1:0]);
               if (empty_c) begin
                  fill_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  state_q <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (!vid_gnt) begin
                  if (cur_word_q == last_word_q) begin
                     if (rows_left_q == 9'd0) begin
                        fill_done_q <= 1'b1;
                        state_q     <= S_DONE;
                     end else begin
                        rows_left_q <= rows_left_q - 9'd1;
                        row_base_q  <= row_base_q + AW'(H_WORDS);
                        cur_word_q  <= first_word_q;
                     end
                  end else begin
                     cur_word_q <= cur_word_q + 9'd1;
                  end
               end
            end
            S_DONE: begin
               cmd_ready_q <= 1'b1;
               fill_busy_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: directed bench for frame_buf_sched with a pixel-level write model
// and a per-cycle port/read-return monitor. Clip cases build with FRAME_FILL_CLIP_EN.
module tb_frame_buf_sched;
   logic        clk = 1'b0;
   logic        reset_reset_n;
   logic        vid_req;
   logic [16:0] vid_addr;
   logic        vid_gnt;
   logic [31:0] vid_rdata;
   logic        vid_rvalid;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [9:0]  cmd_w;
   logic [8:0]  cmd_h;
   logic [7:0]  cmd_color;
   logic        fill_busy;
   logic        fill_done;
   logic [16:0] frame_buf_address;
   logic        frame_buf_chipselect;
   logic        frame_buf_clken;
   logic        frame_buf_write;
   logic [31:0] frame_buf_writedata;
   logic [3:0]  frame_buf_byteenable;
   logic [31:0] frame_buf_readdata;

   typedef struct {
      logic [16:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } wr_t;

   wr_t         wq[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic        g1 = 1'b0, g2 = 1'b0;
   logic [16:0] a1 = '0, a2 = '0;

   frame_buf_sched dut (
      .clk_clk              (clk),
      .reset_reset_n        (reset_reset_n),
      .vid_req              (vid_req),
      .vid_addr             (vid_addr),
      .vid_gnt              (vid_gnt),
      .vid_rdata            (vid_rdata),
      .vid_rvalid           (vid_rvalid),
      .cmd_valid            (cmd_valid),
      .cmd_ready            (cmd_ready),
      .cmd_x                (cmd_x),
      .cmd_y                (cmd_y),
      .cmd_w                (cmd_w),
      .cmd_h                (cmd_h),
      .cmd_color            (cmd_color),
      .fill_busy            (fill_busy),
      .fill_done            (fill_done),
      .frame_buf_address    (frame_buf_address),
      .frame_buf_chipselect (frame_buf_chipselect),
      .frame_buf_clken      (frame_buf_clken),
      .frame_buf_write      (frame_buf_write),
      .frame_buf_writedata  (frame_buf_writedata),
      .frame_buf_byteenable (frame_buf_byteenable),
      .frame_buf_readdata   (frame_buf_readdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: a read returns its own word address, one cycle after presentation.
   always @(posedge clk)
      if (frame_buf_chipselect && !frame_buf_write)
         frame_buf_readdata <= {15'd0, frame_buf_address};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Expected writes derived pixel by pixel from the rectangle.
   task automatic expect_fill(input int x, input int y, input int w, input int h,
                              input logic [7:0] c);
      int  x1, y1;
      wr_t e;
      if (w == 0 || h == 0) return;
      x1 = x + w - 1;
      y1 = y + h - 1;
`ifdef FRAME_FILL_CLIP_EN
      if (x >= 640 || y >= 480) return;
      if (x1 > 639) x1 = 639;
      if (y1 > 479) y1 = 479;
`endif
      for (int r = y; r <= y1; r++) begin
         for (int wd = x / 4; wd <= x1 / 4; wd++) begin
            e.be = 4'h0;
            for (int p = 0; p < 4; p++)
               if (wd * 4 + p >= x && wd * 4 + p <= x1) e.be[p] = 1'b1;
            e.a = 17'((r * 160 + wd) % 131072);
            e.d = {4{c}};
            wq.push_back(e);
         end
      end
   endtask

   // Per-cycle monitor: grants, read returns, port contents, write stream.
   always @(negedge clk) begin
      wr_t e;
      if (!reset_reset_n) begin
         g1 = 1'b0; g2 = 1'b0;
         wq.delete();
      end else begin
         chk("gnt", 32'(vid_gnt), 32'(vid_req));
         chk("rvalid", 32'(vid_rvalid), 32'(g2));
         if (g2) chk("rdata", vid_rdata, {15'd0, a2});
         if (g1) begin
            chk("rd_cs", 32'(frame_buf_chipselect), 32'd1);
            chk("rd_wr", 32'(frame_buf_write), 32'd0);
            chk("rd_addr", 32'(frame_buf_address), 32'(a1));
         end else if (frame_buf_chipselect) begin
            if (!frame_buf_write) chk("spurious_read", 32'(frame_buf_write), 32'd1);
            else if (wq.size() == 0) chk("extra_write", 32'(frame_buf_write), 32'd0);
            else begin
               e = wq.pop_front();
               chk("wr_addr", 32'(frame_buf_address), 32'(e.a));
               chk("wr_be", 32'(frame_buf_byteenable), 32'(e.be));
               chk("wr_data", frame_buf_writedata, e.d);
            end
         end
         chk("done_and_ready", 32'(fill_done & cmd_ready), 32'd0);
         chk("clken", 32'(frame_buf_clken), 32'd1);
         g2 = g1; a2 = a1;
         g1 = vid_gnt; a1 = vid_addr;
      end
   end

   // Issue one command and return cycles from acceptance to fill_done (-1 on timeout).
   task automatic do_fill(input int x, input int y, input int w, input int h,
                          input logic [7:0] c, input bit alt, output int lat);
      int a;
      @(posedge clk); #1;
      cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h);
      cmd_color = c; cmd_valid = 1'b1;
      a = cyc;
      @(negedge clk);
      chk("accept_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = -1;
      for (int i = 0; i < 40000; i++) begin
         @(negedge clk);
         if (fill_done) begin
            lat = cyc - a;
            break;
         end
         @(posedge clk); #1;
         if (alt) begin
            vid_req  = ~vid_req;
            vid_addr = 17'(i * 7 + 3);
         end
      end
      if (lat < 0) chk("done_timeout", 32'(fill_done), 32'd1);
      @(posedge clk); #1;
      vid_req = 1'b0;
      @(negedge clk);
      chk("done_single_pulse", 32'(fill_done), 32'd0);
      chk("ready_after_done", 32'(cmd_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("writes_all_seen", 32'(wq.size()), 32'd0);
   endtask

   initial begin
      int lat;
      reset_reset_n = 1'b0;
      vid_req = 1'b1; vid_addr = 17'h01234;
      cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

      // Reset values with a video request held.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(vid_gnt), 32'd0);
      chk("rst_rvalid", 32'(vid_rvalid), 32'd0);
      chk("rst_rdata", vid_rdata, 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(fill_busy), 32'd0);
      chk("rst_done", 32'(fill_done), 32'd0);
      chk("rst_addr", 32'(frame_buf_address), 32'd0);
      chk("rst_cs", 32'(frame_buf_chipselect), 32'd0);
      chk("rst_wr", 32'(frame_buf_write), 32'd0);
      chk("rst_wdata", frame_buf_writedata, 32'd0);
      chk("rst_be", 32'(frame_buf_byteenable), 32'hF);
      chk("rst_clken", 32'(frame_buf_clken), 32'd1);
      @(posedge clk); #1;
      reset_reset_n = 1'b1;
      @(negedge clk);
      chk("first_gnt", 32'(vid_gnt), 32'd1);
      @(posedge clk); #1;
      vid_req = 1'b0;
      repeat (4) @(negedge clk);

      // Back-to-back video reads.
      @(posedge clk); #1; vid_req = 1'b1; vid_addr = 17'h00000;
      @(posedge clk); #1; vid_addr = 17'h12BFF;
      @(posedge clk); #1; vid_addr = 17'h00001;
      @(negedge clk);
      chk("rd0_data", vid_rdata, 32'h00000);
      chk("rd0_valid", 32'(vid_rvalid), 32'd1);
      @(posedge clk); #1; vid_req = 1'b0;
      @(negedge clk);
      chk("rd1_data", vid_rdata, 32'h12BFF);
      @(negedge clk);
      chk("rd2_data", vid_rdata, 32'h00001);
      @(negedge clk);
      chk("rd_end_valid", 32'(vid_rvalid), 32'd0);

      // Two-word fill, no video.
      expect_fill(1, 2, 6, 1, 8'hA5);
      chk("model_n", 32'(wq.size()), 32'd2);
      chk("model_a0", 32'(wq[0].a), 32'd320);
      chk("model_be0", 32'(wq[0].be), 32'hE);
      chk("model_a1", 32'(wq[1].a), 32'd321);
      chk("model_be1", 32'(wq[1].be), 32'h7);
      chk("model_d0", wq[0].d, 32'hA5A5A5A5);
      do_fill(1, 2, 6, 1, 8'hA5, 1'b0, lat);
      chk("fill_lat", 32'(lat), 32'd4);

      // Same fill with video on alternate cycles.
      expect_fill(1, 2, 6, 1, 8'hA5);
      do_fill(1, 2, 6, 1, 8'hA5, 1'b1, lat);
      chk("fill_alt_lat", 32'(lat), 32'd6);

      // Empty rectangles.
      do_fill(10, 10, 0, 5, 8'h11, 1'b0, lat);
      chk("w0_lat", 32'(lat), 32'd2);
      do_fill(10, 10, 5, 0, 8'h11, 1'b0, lat);
      chk("h0_lat", 32'(lat), 32'd2);

      // Multi-row fill: 3 rows of 3 words.
      expect_fill(5, 10, 9, 3, 8'h3C);
      chk("model_mr_n", 32'(wq.size()), 32'd9);
      do_fill(5, 10, 9, 3, 8'h3C, 1'b0, lat);
      chk("mr_lat", 32'(lat), 32'd11);

      // Single-word rows with both edge masks.
      expect_fill(9, 0, 2, 2, 8'h5A);
      chk("model_sw_be", 32'(wq[0].be), 32'h6);
      do_fill(9, 0, 2, 2, 8'h5A, 1'b1, lat);
      chk("sw_done", 32'(lat > 0), 32'd1);

`ifdef FRAME_FILL_CLIP_EN
      do_fill(700, 10, 5, 5, 8'h22, 1'b0, lat);
      chk("clip_x700_lat", 32'(lat), 32'd2);
      expect_fill(636, 479, 10, 5, 8'h77);
      chk("model_clip_n", 32'(wq.size()), 32'd1);
      chk("model_clip_a", 32'(wq[0].a), 32'd76799);
      chk("model_clip_be", 32'(wq[0].be), 32'hF);
      do_fill(636, 479, 10, 5, 8'h77, 1'b0, lat);
      chk("clip_corner_lat", 32'(lat), 32'd3);
`endif

      // Reset during a 160x100-word fill with video traffic.
      expect_fill(0, 0, 640, 100, 8'hC3);
      @(posedge clk); #1;
      cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd640; cmd_h = 9'd100;
      cmd_color = 8'hC3; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         vid_req = ~vid_req; vid_addr = 17'(i + 100);
      end
      @(posedge clk); #1;
      vid_req = 1'b1;
      @(negedge clk);
      chk("pre_rst_busy", 32'(fill_busy), 32'd1);
      @(posedge clk); #1;
      reset_reset_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_stop_wr", 32'(frame_buf_write), 32'd0);
      chk("rst_stop_cs", 32'(frame_buf_chipselect), 32'd0);
      chk("rst_drop_rvalid", 32'(vid_rvalid), 32'd0);
      chk("rst_idle_busy", 32'(fill_busy), 32'd0);
      @(posedge clk); #1;
      reset_reset_n = 1'b1;
      vid_req = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_no_wr", 32'(frame_buf_write), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
